pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/pipe_stall_ctrl_pkg.sv | 16 +
 rtl/pipe_stall_ctrl_perf_cnt.sv | 14 +
 rtl/pipe_stall_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall controller: stall codes, FSM states, bus width.
package pipe_stall_ctrl_pkg;
  localparam int REG_BUS = 64;

  typedef enum logic [1:0] {
    STALL_NEXT = 2'b00,
    STALL_KEEP = 2'b01,
    STALL_ZERO = 2'b10
  } stall_t;

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_MEM_WAIT   = 2'b01,
    ST_REDIR_WAIT = 2'b10
  } ctrl_state_t;
endpackage

// File: rtl/pipe_stall_ctrl_perf_cnt.sv
// Free-running stall cycle counter; wraps naturally at full width.
module stall_perf_cnt
  import pipe_stall_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  output logic [REG_BUS-1:0] count
);
  always_ff @(posedge clk) begin
    if (rst)      count <= '0;
    else if (inc) count <= count + REG_BUS'(1);
  end
endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard/stall controller: per-stage stall codes, PC redirect and stall counter.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  input  logic               if_busy,
  input  logic               id_load_use,
  input  logic               mem_req,
  input  logic               mem_done,
  input  logic               br_taken,
  input  logic [REG_BUS-1:0] br_target,
  input  logic               trap_req,
  input  logic [REG_BUS-1:0] trap_vec,
  output logic [1:0]         pc_stall,
  output logic [1:0]         if_id_stall,
  output logic [1:0]         id_ex_stall,
  output logic [1:0]         ex_me_stall,
  output logic [1:0]         me_wb_stall,
  output logic               redirect_valid,
  output logic [REG_BUS-1:0] redirect_pc,
  output logic [REG_BUS-1:0] stall_cycles
);
  ctrl_state_t        state, state_nxt;
  logic [REG_BUS-1:0] tgt_q, tgt_d;
  logic               tgt_ld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      tgt_q <= '0;
    end else begin
      state <= state_nxt;
      if (tgt_ld) tgt_q <= tgt_d;
    end
  end

  always_comb begin
    pc_stall       = STALL_NEXT;
    if_id_stall    = STALL_NEXT;
    id_ex_stall    = STALL_NEXT;
    ex_me_stall    = STALL_NEXT;
    me_wb_stall    = STALL_NEXT;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    state_nxt      = state;
    tgt_ld         = 1'b0;
    tgt_d          = trap_req ? trap_vec : br_target;
    if (rst) begin
      pc_stall    = STALL_ZERO;
      if_id_stall = STALL_ZERO;
      id_ex_stall = STALL_ZERO;
      ex_me_stall = STALL_ZERO;
      me_wb_stall = STALL_ZERO;
      state_nxt   = ST_RUN;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (trap_req || br_taken) begin
            if_id_stall = STALL_ZERO;
            id_ex_stall = STALL_ZERO;
            ex_me_stall = STALL_ZERO;
            // Fetch bus still busy: park the target until it can be issued
            if (if_busy) begin
              pc_stall  = STALL_KEEP;
              tgt_ld    = 1'b1;
              state_nxt = ST_REDIR_WAIT;
            end else begin
              redirect_valid = 1'b1;
              redirect_pc    = tgt_d;
            end
          end else if (mem_req && !mem_done) begin
            pc_stall    = STALL_KEEP;
            if_id_stall = STALL_KEEP;
            id_ex_stall = STALL_KEEP;
            ex_me_stall = STALL_KEEP;
            me_wb_stall = STALL_ZERO;
            state_nxt   = ST_MEM_WAIT;
          end else if (id_load_use) begin
            pc_stall    = STALL_KEEP;
            if_id_stall = STALL_KEEP;
            id_ex_stall = STALL_ZERO;
          end else if (!if_valid) begin
            pc_stall    = STALL_KEEP;
            if_id_stall = STALL_ZERO;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_done) begin
            state_nxt = ST_RUN;
          end else begin
            pc_stall    = STALL_KEEP;
            if_id_stall = STALL_KEEP;
            id_ex_stall = STALL_KEEP;
            ex_me_stall = STALL_KEEP;
            me_wb_stall = STALL_ZERO;
          end
        end
        ST_REDIR_WAIT: begin
          if_id_stall = STALL_ZERO;
          id_ex_stall = STALL_ZERO;
          ex_me_stall = STALL_ZERO;
          if (if_busy) begin
            pc_stall = STALL_KEEP;
          end else begin
            redirect_valid = 1'b1;
            redirect_pc    = tgt_q;
            state_nxt      = ST_RUN;
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  stall_perf_cnt u_perf_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_stall != STALL_NEXT),
    .count (stall_cycles)
  );
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed + random bench for pipe_stall_ctrl against a behavioural hazard model.
module tb_pipe_stall_ctrl;
  localparam logic [1:0] NX = 2'b00, KP = 2'b01, ZR = 2'b10;

  logic        clk = 1'b0;
  logic        rst, if_valid, if_busy, id_load_use, mem_req, mem_done, br_taken, trap_req;
  logic [63:0] br_target, trap_vec;
  logic [1:0]  pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc, stall_cycles;

  int checks = 0;
  int failures = 0;

  // Model: a pending memory wait, a pending redirect (with its target), and the stall tally.
  bit          m_mem_pending, m_redir_pending;
  logic [63:0] m_tgt, m_cnt;
  logic [1:0]  e_pc, e_ifid, e_idex, e_exme, e_mewb;
  logic        e_rv;
  logic [63:0] e_rpc;

  pipe_stall_ctrl dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_busy(if_busy),
    .id_load_use(id_load_use), .mem_req(mem_req), .mem_done(mem_done),
    .br_taken(br_taken), .br_target(br_target), .trap_req(trap_req), .trap_vec(trap_vec),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_me_stall(ex_me_stall), .me_wb_stall(me_wb_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_codes(input logic [1:0] p, i, d, e, w);
    e_pc = p; e_ifid = i; e_idex = d; e_exme = e; e_mewb = w;
  endtask

  // What the outputs must be this cycle, from the hazard rules.
  task automatic model_eval();
    e_rv = 1'b0; e_rpc = 64'd0;
    if (rst) set_codes(ZR, ZR, ZR, ZR, ZR);
    else if (m_mem_pending) begin
      if (mem_done) set_codes(NX, NX, NX, NX, NX);
      else          set_codes(KP, KP, KP, KP, ZR);
    end else if (m_redir_pending) begin
      set_codes(if_busy ? KP : NX, ZR, ZR, ZR, NX);
      if (!if_busy) begin e_rv = 1'b1; e_rpc = m_tgt; end
    end else if (trap_req || br_taken) begin
      set_codes(if_busy ? KP : NX, ZR, ZR, ZR, NX);
      if (!if_busy) begin e_rv = 1'b1; e_rpc = trap_req ? trap_vec : br_target; end
    end else if (mem_req && !mem_done) set_codes(KP, KP, KP, KP, ZR);
    else if (id_load_use)              set_codes(KP, KP, ZR, NX, NX);
    else if (!if_valid)                set_codes(KP, ZR, NX, NX, NX);
    else                               set_codes(NX, NX, NX, NX, NX);
  endtask

  task automatic model_advance();
    if (rst) begin
      m_mem_pending = 0; m_redir_pending = 0; m_tgt = 0; m_cnt = 0;
    end else begin
      if (e_pc != NX) m_cnt = m_cnt + 64'd1;
      if (m_mem_pending) m_mem_pending = !mem_done;
      else if (m_redir_pending) m_redir_pending = if_busy;
      else if (trap_req || br_taken) begin
        if (if_busy) begin m_redir_pending = 1; m_tgt = trap_req ? trap_vec : br_target; end
      end else if (mem_req && !mem_done) m_mem_pending = 1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  // Compare every output against the model, then let the clock edge happen.
  task automatic finish_cycle();
    chk("pc_stall", 64'(pc_stall), 64'(e_pc));
    chk("if_id_stall", 64'(if_id_stall), 64'(e_ifid));
    chk("id_ex_stall", 64'(id_ex_stall), 64'(e_idex));
    chk("ex_me_stall", 64'(ex_me_stall), 64'(e_exme));
    chk("me_wb_stall", 64'(me_wb_stall), 64'(e_mewb));
    chk("redirect_valid", 64'(redirect_valid), 64'(e_rv));
    chk("redirect_pc", redirect_pc, e_rpc);
    chk("stall_cycles", stall_cycles, m_cnt);
    model_advance();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rst = 0; if_valid = 1; if_busy = 0; id_load_use = 0; mem_req = 0; mem_done = 0;
    br_taken = 0; trap_req = 0; br_target = 64'h0; trap_vec = 64'h0;
  endtask

  task automatic do_reset();
    idle(); rst = 1;
    settle(); finish_cycle();
    settle(); finish_cycle();
    rst = 0;
  endtask

  initial begin
    m_mem_pending = 0; m_redir_pending = 0; m_tgt = 0; m_cnt = 0;
    idle(); rst = 1;
    @(posedge clk); #1;
    settle();
    chk("rst_pc_zero", 64'(pc_stall), 64'(ZR));
    chk("rst_mewb_zero", 64'(me_wb_stall), 64'(ZR));
    chk("rst_rv", 64'(redirect_valid), 64'd0);
    finish_cycle();
    settle(); finish_cycle();
    chk("rst_cnt", stall_cycles, 64'd0);
    rst = 0;

    // Memory wait: done low for 3 cycles then high
    mem_req = 1; mem_done = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("mem_exme_keep", 64'(ex_me_stall), 64'(KP));
      chk("mem_mewb_zero", 64'(me_wb_stall), 64'(ZR));
      finish_cycle();
    end
    mem_done = 1;
    settle();
    chk("mem_done_pc", 64'(pc_stall), 64'(NX));
    chk("mem_done_mewb", 64'(me_wb_stall), 64'(NX));
    finish_cycle();
    idle();
    settle();
    chk("mem_cnt3", stall_cycles, 64'd3);
    finish_cycle();

    // Same-cycle mem handshake causes no stall
    mem_req = 1; mem_done = 1;
    settle(); chk("mem_nostall_pc", 64'(pc_stall), 64'(NX)); finish_cycle();
    idle();

    // Immediate branch redirect
    br_taken = 1; br_target = 64'h8000_0100;
    settle();
    chk("br_rv", 64'(redirect_valid), 64'd1);
    chk("br_rpc", redirect_pc, 64'h8000_0100);
    chk("br_ifid", 64'(if_id_stall), 64'(ZR));
    chk("br_exme", 64'(ex_me_stall), 64'(ZR));
    finish_cycle();
    idle();

    // Branch with fetch busy for 2 cycles; pulse on the third
    br_taken = 1; br_target = 64'h8000_0100; if_busy = 1;
    settle(); chk("brw0_pc", 64'(pc_stall), 64'(KP)); chk("brw0_rv", 64'(redirect_valid), 64'd0); finish_cycle();
    br_taken = 1; br_target = 64'h1234;  // ignored while waiting
    settle(); chk("brw1_pc", 64'(pc_stall), 64'(KP)); chk("brw1_rv", 64'(redirect_valid), 64'd0); finish_cycle();
    idle();
    settle(); chk("brw2_rv", 64'(redirect_valid), 64'd1); chk("brw2_rpc", redirect_pc, 64'h8000_0100); finish_cycle();
    settle(); chk("brw3_rv", 64'(redirect_valid), 64'd0); finish_cycle();

    // Trap beats branch
    trap_req = 1; br_taken = 1; trap_vec = 64'h8000_0004; br_target = 64'h8000_0100;
    settle(); chk("trap_rpc", redirect_pc, 64'h8000_0004); finish_cycle();
    idle();

    // Load-use with fetch bubble: load-use wins
    id_load_use = 1; if_valid = 0;
    settle();
    chk("lu_pc", 64'(pc_stall), 64'(KP));
    chk("lu_ifid", 64'(if_id_stall), 64'(KP));
    chk("lu_idex", 64'(id_ex_stall), 64'(ZR));
    chk("lu_exme", 64'(ex_me_stall), 64'(NX));
    finish_cycle();
    idle(); if_valid = 0;
    settle(); chk("ifv_ifid", 64'(if_id_stall), 64'(ZR)); finish_cycle();
    idle();

    // Reset while a redirect is pending
    br_taken = 1; br_target = 64'h8000_0100; if_busy = 1;
    settle(); finish_cycle();
    idle(); rst = 1;
    settle(); chk("rstw_rv", 64'(redirect_valid), 64'd0); finish_cycle();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      settle(); chk("rstw_after_rv", 64'(redirect_valid), 64'd0); finish_cycle();
    end
    chk("rstw_cnt", stall_cycles, 64'd0);

    // Random traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 59) == 0);
      if_valid    = ($urandom_range(0, 4) != 0);
      if_busy     = $urandom_range(0, 1) == 1;
      id_load_use = ($urandom_range(0, 4) == 0);
      mem_req     = ($urandom_range(0, 3) == 0);
      mem_done    = ($urandom_range(0, 2) == 0);
      br_taken    = ($urandom_range(0, 5) == 0);
      trap_req    = ($urandom_range(0, 9) == 0);
      br_target   = {$urandom, $urandom};
      trap_vec    = {$urandom, $urandom};
      settle(); finish_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
